// File: rtl/int_requester.sv
// Device-side interrupt requester: edge-collects peripheral and NMI events, drives INT/NMI,
// answers the CPU acknowledge with a vector and holds off new requests until end-of-interrupt.
module int_requester #(
    parameter int                N_SRC    = 4,
    parameter int                VEC_W    = 8,
    parameter logic [VEC_W-1:0]  VEC_BASE = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic              nmi_src,
    input  logic              mask_wr,
    input  logic [N_SRC-1:0]  mask_data,
    input  logic              INA,
    input  logic              eoi,
    output logic              INT,
    output logic              NMI,
    output logic [VEC_W-1:0]  vector,
    output logic              vector_valid,
    output logic [N_SRC-1:0]  pending,
    output logic              in_service
);

    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ_NMI = 2'd1,
        S_REQ_INT = 2'd2,
        S_SERVE   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    id, id_nxt;
    logic [N_SRC-1:0]   mask;
    logic               nmi_pend;
    logic [N_SRC-1:0]   irq_prev;
    logic               nmi_prev;
    logic               ina_prev;

    logic [N_SRC-1:0]   irq_rise;
    logic               nmi_rise;
    logic               ina_rise;
    logic [N_SRC-1:0]   enabled;
    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic               ack_nmi;
    logic               ack_int;
    logic [N_SRC-1:0]   pend_clr;
    logic [VEC_W-1:0]   int_vector;

    assign irq_rise   = irq_src & ~irq_prev;
    assign nmi_rise   = nmi_src & ~nmi_prev;
    assign ina_rise   = INA & ~ina_prev;
    assign enabled    = pending & mask;
    assign int_vector = VEC_BASE + VEC_W'(1) + VEC_W'(id);

    // Fixed priority: index 0 wins, so scan from the top and let lower indices overwrite.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            id    <= '0;
        end else begin
            state <= state_nxt;
            id    <= id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        ack_nmi   = 1'b0;
        ack_int   = 1'b0;
        case (state)
            S_IDLE: begin
                if (nmi_pend) begin
                    state_nxt = S_REQ_NMI;
                end else if (sel_found) begin
                    id_nxt    = sel_idx;
                    state_nxt = S_REQ_INT;
                end
            end
            S_REQ_NMI: begin
                if (ina_rise) begin
                    ack_nmi   = 1'b1;
                    state_nxt = S_SERVE;
                end
            end
            S_REQ_INT: begin
                // NMI preemption beats a concurrent acknowledge; id's pending bit is left set.
                if (nmi_pend) begin
                    state_nxt = S_REQ_NMI;
                end else if (!mask[id]) begin
                    state_nxt = S_IDLE;
                end else if (ina_rise) begin
                    ack_int   = 1'b1;
                    state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (eoi) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pend_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pend_clr[i] = ack_int && (id == ID_W'(i));
        end
    end

    // A new edge landing on the bit being acknowledged survives: set is applied after clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            nmi_prev <= 1'b0;
            ina_prev <= 1'b0;
            pending  <= '0;
            nmi_pend <= 1'b0;
            mask     <= '1;
        end else begin
            irq_prev <= irq_src;
            nmi_prev <= nmi_src;
            ina_prev <= INA;
            pending  <= (pending & ~pend_clr) | irq_rise;
            nmi_pend <= (nmi_pend & ~ack_nmi) | nmi_rise;
            if (mask_wr) begin
                mask <= mask_data;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            INT          <= 1'b0;
            NMI          <= 1'b0;
            in_service   <= 1'b0;
            vector_valid <= 1'b0;
            vector       <= '0;
        end else begin
            INT          <= (state_nxt == S_REQ_INT);
            NMI          <= (state_nxt == S_REQ_NMI);
            in_service   <= (state_nxt == S_SERVE);
            vector_valid <= ack_nmi | ack_int;
            if (ack_nmi) begin
                vector <= VEC_BASE;
            end else if (ack_int) begin
                vector <= int_vector;
            end
        end
    end

endmodule

// File: tb/tb_int_requester.sv
// Bench for int_requester: directed handshake scenarios plus a randomized run against a
// cycle-level model of the request/acknowledge/end-of-interrupt rules.
module tb_int_requester;

    localparam int N = 4;
    localparam int BASE = 'h20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq_src = '0;
    logic         nmi_src = 1'b0;
    logic         mask_wr = 1'b0;
    logic [N-1:0] mask_data = '0;
    logic         INA = 1'b0;
    logic         eoi = 1'b0;
    logic         INT;
    logic         NMI;
    logic [7:0]   vector;
    logic         vector_valid;
    logic [N-1:0] pending;
    logic         in_service;

    int n_checks = 0;
    int n_pass   = 0;

    int_requester #(.N_SRC(N), .VEC_W(8), .VEC_BASE(8'h20)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .nmi_src(nmi_src),
        .mask_wr(mask_wr), .mask_data(mask_data), .INA(INA), .eoi(eoi),
        .INT(INT), .NMI(NMI), .vector(vector), .vector_valid(vector_valid),
        .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        irq_src = '0; nmi_src = 1'b0; mask_wr = 1'b0; mask_data = '0; INA = 1'b0; eoi = 1'b0;
    endtask

    // Acknowledge then end-of-interrupt, checking the vector the CPU receives.
    task automatic ack_and_eoi(input string tag, input logic [7:0] exp_vec);
        INA = 1'b1; tick();
        n_checks++; if (vector_valid !== 1'b1 || vector !== exp_vec) $display("FAIL %s_vec got=%b/%h exp=1/%h", tag, vector_valid, vector, exp_vec); else n_pass++;
        n_checks++; if (INT !== 1'b0 || NMI !== 1'b0 || in_service !== 1'b1) $display("FAIL %s_ack_lines got INT=%b NMI=%b svc=%b exp 0/0/1", tag, INT, NMI, in_service); else n_pass++;
        INA = 1'b0; tick();
        n_checks++; if (vector_valid !== 1'b0 || vector !== exp_vec) $display("FAIL %s_vhold got=%b/%h exp=0/%h", tag, vector_valid, vector, exp_vec); else n_pass++;
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_checks++; if (in_service !== 1'b0) $display("FAIL %s_eoi got svc=%b exp=0", tag, in_service); else n_pass++;
    endtask

    task automatic test_reset();
        quiet(); rst = 1'b1;
        tick(); tick();
        n_checks++; if ({INT, NMI, vector_valid, in_service} !== 4'b0000) $display("FAIL reset_lines got=%b exp=0000", {INT, NMI, vector_valid, in_service}); else n_pass++;
        n_checks++; if (vector !== 8'h00 || pending !== 4'h0) $display("FAIL reset_regs got vec=%h pend=%b exp 00/0000", vector, pending); else n_pass++;
        rst = 1'b0; tick();
        n_checks++; if (INT !== 1'b0 || pending !== 4'h0) $display("FAIL reset_idle got INT=%b pend=%b exp 0/0000", INT, pending); else n_pass++;
    endtask

    task automatic test_basic();
        irq_src = 4'b0100; tick();
        n_checks++; if (pending !== 4'b0100 || INT !== 1'b0) $display("FAIL basic_pend got pend=%b INT=%b exp 0100/0", pending, INT); else n_pass++;
        irq_src = '0; tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL basic_int got=%b exp=1", INT); else n_pass++;
        ack_and_eoi("basic", 8'h23);
        n_checks++; if (pending !== 4'b0000) $display("FAIL basic_pclr got=%b exp=0000", pending); else n_pass++;
    endtask

    task automatic test_priority();
        irq_src = 4'b1010; tick(); irq_src = '0; tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL prio_int1 got=%b exp=1", INT); else n_pass++;
        ack_and_eoi("prio1", 8'h22);
        tick();
        n_checks++; if (INT !== 1'b1 || pending !== 4'b1000) $display("FAIL prio_int3 got INT=%b pend=%b exp 1/1000", INT, pending); else n_pass++;
        ack_and_eoi("prio3", 8'h24);
    endtask

    task automatic test_nmi_preempt();
        irq_src = 4'b0001; tick(); irq_src = '0; tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL pre_int got=%b exp=1", INT); else n_pass++;
        nmi_src = 1'b1; tick();
        n_checks++; if (INT !== 1'b1 || NMI !== 1'b0) $display("FAIL pre_k got INT=%b NMI=%b exp 1/0", INT, NMI); else n_pass++;
        nmi_src = 1'b0; tick();
        n_checks++; if (INT !== 1'b0 || NMI !== 1'b1 || pending !== 4'b0001) $display("FAIL pre_k1 got INT=%b NMI=%b pend=%b exp 0/1/0001", INT, NMI, pending); else n_pass++;
        ack_and_eoi("pre_nmi", 8'h20);
        tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL pre_rereq got=%b exp=1", INT); else n_pass++;
        ack_and_eoi("pre_src0", 8'h21);
    endtask

    task automatic test_mask();
        irq_src = 4'b0001; tick(); irq_src = '0; tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL mask_int got=%b exp=1", INT); else n_pass++;
        mask_wr = 1'b1; mask_data = 4'b1110; tick(); mask_wr = 1'b0;
        n_checks++; if (INT !== 1'b1) $display("FAIL mask_lat got=%b exp=1", INT); else n_pass++;
        tick();
        n_checks++; if (INT !== 1'b0 || pending !== 4'b0001) $display("FAIL mask_drop got INT=%b pend=%b exp 0/0001", INT, pending); else n_pass++;
        tick(); tick();
        n_checks++; if (INT !== 1'b0) $display("FAIL mask_stay got=%b exp=0", INT); else n_pass++;
        mask_wr = 1'b1; mask_data = 4'b1111; tick(); mask_wr = 1'b0; tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL mask_unmask got=%b exp=1", INT); else n_pass++;
        ack_and_eoi("mask", 8'h21);
    endtask

    task automatic test_ack_collision();
        irq_src = 4'b0010; tick(); irq_src = '0; tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL coll_int got=%b exp=1", INT); else n_pass++;
        INA = 1'b1; irq_src = 4'b0010; tick();
        n_checks++; if (vector_valid !== 1'b1 || vector !== 8'h22 || pending !== 4'b0010) $display("FAIL coll_ack got vv=%b vec=%h pend=%b exp 1/22/0010", vector_valid, vector, pending); else n_pass++;
        INA = 1'b0; irq_src = '0; tick();
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        n_checks++; if (INT !== 1'b1) $display("FAIL coll_rereq got=%b exp=1", INT); else n_pass++;
        ack_and_eoi("coll", 8'h22);
    endtask

    task automatic test_reset_mid();
        nmi_src = 1'b1; irq_src = 4'b0001; tick(); quiet(); tick();
        n_checks++; if (NMI !== 1'b1 || pending !== 4'b0001) $display("FAIL rmid_nmi got NMI=%b pend=%b exp 1/0001", NMI, pending); else n_pass++;
        #2 rst = 1'b1; #1;
        n_checks++; if (NMI !== 1'b0 || pending !== 4'b0000 || in_service !== 1'b0) $display("FAIL rmid_async got NMI=%b pend=%b svc=%b exp 0/0000/0", NMI, pending, in_service); else n_pass++;
        tick(); rst = 1'b0; tick();
        INA = 1'b1; tick(); INA = 1'b0; tick();
        n_checks++; if ({INT, NMI, vector_valid, in_service} !== 4'b0000) $display("FAIL rmid_ina got=%b exp=0000", {INT, NMI, vector_valid, in_service}); else n_pass++;
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        n_checks++; if ({INT, NMI, in_service} !== 3'b000 || pending !== 4'h0) $display("FAIL rmid_eoi got=%b pend=%b exp 000/0000", {INT, NMI, in_service}, pending); else n_pass++;
    endtask

    // Reference model: phase 0 idle, 1 requesting NMI, 2 requesting INT, 3 serving.
    bit [N-1:0] m_pend, m_mask, m_pirq;
    bit         m_npend, m_pnmi, m_pina;
    int         m_phase, m_id;
    bit         m_vv;
    bit [7:0]   m_vec;

    task automatic model_reset();
        m_pend = '0; m_mask = '1; m_pirq = '0; m_npend = 0; m_pnmi = 0; m_pina = 0;
        m_phase = 0; m_id = 0; m_vv = 0; m_vec = 8'h00;
    endtask

    task automatic model_step(input bit [N-1:0] irq, input bit nmi, input bit mw,
                              input bit [N-1:0] md, input bit ina, input bit ev);
        bit [N-1:0] rise;
        bit         ack_edge;
        int         lo;
        rise     = irq & ~m_pirq;
        ack_edge = ina && !m_pina;
        m_vv     = 0;
        if (m_phase == 0) begin
            lo = -1;
            for (int i = 0; i < N; i++) if (lo < 0 && m_pend[i] && m_mask[i]) lo = i;
            if (m_npend) m_phase = 1;
            else if (lo >= 0) begin m_id = lo; m_phase = 2; end
        end else if (m_phase == 1) begin
            if (ack_edge) begin m_npend = 0; m_vec = 8'(BASE); m_vv = 1; m_phase = 3; end
        end else if (m_phase == 2) begin
            if (m_npend) m_phase = 1;
            else if (!m_mask[m_id]) m_phase = 0;
            else if (ack_edge) begin m_pend[m_id] = 0; m_vec = 8'((BASE + 1 + m_id) % 256); m_vv = 1; m_phase = 3; end
        end else begin
            if (ev) m_phase = 0;
        end
        m_pend  = m_pend | rise;
        if (nmi && !m_pnmi) m_npend = 1;
        if (mw) m_mask = md;
        m_pirq = irq; m_pnmi = nmi; m_pina = ina;
    endtask

    task automatic test_random();
        quiet(); rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) irq_src = N'($urandom);
            if ($urandom_range(0, 30) == 0) nmi_src = ~nmi_src;
            mask_wr = ($urandom_range(0, 19) == 0);
            mask_data = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 2) == 0) INA = ~INA;
            eoi = ($urandom_range(0, 6) == 0);
            model_step(irq_src, nmi_src, mask_wr, mask_data, INA, eoi);
            tick();
            n_checks++; if (INT !== (m_phase == 2) || NMI !== (m_phase == 1) || in_service !== (m_phase == 3)) $display("FAIL rand_lines c=%0d got INT=%b NMI=%b svc=%b exp phase=%0d", c, INT, NMI, in_service, m_phase); else n_pass++;
            n_checks++; if (pending !== m_pend) $display("FAIL rand_pend c=%0d got=%b exp=%b", c, pending, m_pend); else n_pass++;
            n_checks++; if (vector_valid !== m_vv || vector !== m_vec) $display("FAIL rand_vec c=%0d got=%b/%h exp=%b/%h", c, vector_valid, vector, m_vv, m_vec); else n_pass++;
        end
        quiet(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_nmi_preempt();
        test_mask();
        test_ack_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
